// File: rtl/adc_pkt_pkg.sv
// Shared types and constants for the ADC Avalon-ST packetizer.
// Header beat support is compiled in with ADC_PKT_HEADER_EN.
package adc_pkt_pkg;

    localparam int BEAT_W        = 512;
    localparam int SAMPLE_W_DFLT = 32;
    localparam int SPB           = BEAT_W / SAMPLE_W_DFLT;
    localparam int EMPTY_W       = 6;
    localparam logic [31:0] HDR_MAGIC = 32'hADC0_5EED;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HDR   = 2'd1,
        ACQ   = 2'd2,
        ABORT = 2'd3
    } state_t;

    typedef struct packed {
        logic [BEAT_W-1:0]  data;
        logic               sop;
        logic               eop;
        logic [EMPTY_W-1:0] empty;
    } beat_t;

endpackage

// File: rtl/adc_pkt_beat_fifo.sv
// Show-ahead beat FIFO; the head beat is re-registered from the array every cycle,
// so a freshly written beat appears on the output one cycle after its write.
module adc_pkt_beat_fifo
    import adc_pkt_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push_i,
    input  beat_t push_beat_i,
    output logic  full_o,
    input  logic  out_ready_i,
    output beat_t out_beat_o,
    output logic  out_valid_o
);

    localparam int AW = $clog2(DEPTH);

    beat_t        mem [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    beat_t        out_beat_q, out_beat_d;
    logic         out_valid_q, out_valid_d;
    logic         pop;
    logic         wr_en;

    assign pop    = out_valid_q & out_ready_i;
    assign full_o = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // A pop in the same cycle frees the slot the push may use.
    assign wr_en  = push_i & (~full_o | pop);

    always_comb begin
        wr_ptr_d    = wr_ptr_q + (AW+1)'(wr_en);
        rd_ptr_d    = rd_ptr_q + (AW+1)'(pop);
        out_valid_d = (rd_ptr_d != wr_ptr_q);
        out_beat_d  = '0;
        if (out_valid_d) begin
            out_beat_d = mem[rd_ptr_d[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[AW-1:0]] <= push_beat_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_beat_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_beat_q  <= out_beat_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_beat_o  = out_beat_q;
    assign out_valid_o = out_valid_q;

endmodule

// File: rtl/adc_st_packetizer.sv
// Packs ADC samples into triggered Avalon-ST packets of 512-bit beats.
// Define ADC_PKT_HEADER_EN to prepend a header beat with sequence number and timestamp.
module adc_st_packetizer
    import adc_pkt_pkg::*;
#(
    parameter int SAMPLE_W  = SAMPLE_W_DFLT,
    parameter int BUF_DEPTH = 4,
    parameter int LEN_W     = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [SAMPLE_W-1:0] smp_data,
    input  logic                smp_valid,
    input  logic                trig,
    input  logic [LEN_W-1:0]    pkt_len,
    output logic [BEAT_W-1:0]   st_data,
    output logic                st_valid,
    input  logic                st_ready,
    output logic                st_sop,
    output logic                st_eop,
    output logic [5:0]          st_empty,
    output logic                busy,
    output logic [15:0]         ovf_cnt,
    output logic [31:0]         pkt_seq
);

    localparam int SMP_PER_BEAT = BEAT_W / SAMPLE_W;
    localparam int IDX_W        = $clog2(SMP_PER_BEAT);

    state_t             state_q, state_d;
    logic [BEAT_W-1:0]  pack_q, pack_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic               first_q, first_d;
    logic [15:0]        ovf_q, ovf_d;
    logic [31:0]        seq_q, seq_d;
`ifdef ADC_PKT_HEADER_EN
    logic [LEN_W-1:0]   len_q, len_d;
    logic [63:0]        ts_cnt_q, ts_cnt_d;
    logic [63:0]        ts_q, ts_d;
`endif

    logic               push;
    beat_t              push_beat;
    logic               fifo_full;
    beat_t              out_beat;
    logic               out_valid;
    logic               can_push;
    logic               drop;
    logic               last_smp;
    logic               beat_full;
    logic [BEAT_W-1:0]  beat_data;

    assign can_push  = ~fifo_full | (out_valid & st_ready);
    assign last_smp  = (rem_q == LEN_W'(1));
    assign beat_full = (idx_q == IDX_W'(SMP_PER_BEAT - 1));

    always_comb begin
        state_d   = state_q;
        pack_d    = pack_q;
        idx_d     = idx_q;
        rem_d     = rem_q;
        first_d   = first_q;
        ovf_d     = ovf_q;
        seq_d     = seq_q;
`ifdef ADC_PKT_HEADER_EN
        len_d     = len_q;
        ts_cnt_d  = ts_cnt_q + 64'd1;
        ts_d      = ts_q;
`endif
        push      = 1'b0;
        push_beat = '0;
        drop      = 1'b0;
        // First sample of a beat lands in the top bits.
        beat_data = pack_q;
        beat_data[BEAT_W-1 - int'(idx_q)*SAMPLE_W -: SAMPLE_W] = smp_data;

        case (state_q)
            IDLE: begin
                if (trig && (pkt_len != '0)) begin
                    rem_d   = pkt_len;
                    seq_d   = seq_q + 32'd1;
                    pack_d  = '0;
                    idx_d   = '0;
                    first_d = 1'b1;
`ifdef ADC_PKT_HEADER_EN
                    len_d   = pkt_len;
                    ts_d    = ts_cnt_q;
                    state_d = HDR;
`else
                    state_d = ACQ;
`endif
                end
            end
            HDR: begin
`ifdef ADC_PKT_HEADER_EN
                drop = smp_valid;
                if (can_push) begin
                    push            = 1'b1;
                    push_beat.data  = {HDR_MAGIC, seq_q, ts_q, 16'h0, 16'(len_q),
                                       {(BEAT_W-160){1'b0}}};
                    push_beat.sop   = 1'b1;
                    first_d         = 1'b0;
                    state_d         = ACQ;
                end
`else
                state_d = IDLE;
`endif
            end
            ACQ: begin
                if (smp_valid) begin
                    rem_d = rem_q - LEN_W'(1);
                    if (beat_full || last_smp) begin
                        push_beat.data  = beat_data;
                        push_beat.sop   = first_q;
                        push_beat.eop   = last_smp;
                        push_beat.empty = last_smp ?
                            EMPTY_W'((SMP_PER_BEAT - int'(idx_q) - 1) * (SAMPLE_W/8)) : '0;
                        if (can_push) begin
                            push    = 1'b1;
                            pack_d  = '0;
                            idx_d   = '0;
                            first_d = 1'b0;
                            if (last_smp) begin
                                state_d = IDLE;
                            end
                        end else begin
                            pack_d  = beat_data;
                            state_d = ABORT;
                        end
                    end else begin
                        pack_d = beat_data;
                        idx_d  = idx_q + IDX_W'(1);
                    end
                end
            end
            ABORT: begin
                drop = smp_valid;
                if (can_push) begin
                    push           = 1'b1;
                    push_beat.data = pack_q;
                    push_beat.sop  = first_q;
                    push_beat.eop  = 1'b1;
                    pack_d         = '0;
                    idx_d          = '0;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (drop && (ovf_q != 16'hFFFF)) begin
            ovf_d = ovf_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            pack_q   <= '0;
            idx_q    <= '0;
            rem_q    <= '0;
            first_q  <= 1'b0;
            ovf_q    <= '0;
            seq_q    <= '0;
`ifdef ADC_PKT_HEADER_EN
            len_q    <= '0;
            ts_cnt_q <= '0;
            ts_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            pack_q   <= pack_d;
            idx_q    <= idx_d;
            rem_q    <= rem_d;
            first_q  <= first_d;
            ovf_q    <= ovf_d;
            seq_q    <= seq_d;
`ifdef ADC_PKT_HEADER_EN
            len_q    <= len_d;
            ts_cnt_q <= ts_cnt_d;
            ts_q     <= ts_d;
`endif
        end
    end

    adc_pkt_beat_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (reset_n),
        .push_i      (push),
        .push_beat_i (push_beat),
        .full_o      (fifo_full),
        .out_ready_i (st_ready),
        .out_beat_o  (out_beat),
        .out_valid_o (out_valid)
    );

    assign st_data  = out_beat.data;
    assign st_sop   = out_beat.sop;
    assign st_eop   = out_beat.eop;
    assign st_empty = out_beat.empty;
    assign st_valid = out_valid;
    assign busy     = (state_q != IDLE);
    assign ovf_cnt  = ovf_q;
    assign pkt_seq  = seq_q;

endmodule

// File: tb/tb_adc_st_packetizer.sv
// Directed bench for adc_st_packetizer; beats are logged as they transfer.
module tb_adc_st_packetizer;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [31:0]  smp_data = '0;
    logic         smp_valid = 1'b0;
    logic         trig = 1'b0;
    logic [15:0]  pkt_len = '0;
    logic [511:0] st_data;
    logic         st_valid;
    logic         st_ready = 1'b1;
    logic         st_sop;
    logic         st_eop;
    logic [5:0]   st_empty;
    logic         busy;
    logic [15:0]  ovf_cnt;
    logic [31:0]  pkt_seq;

    typedef struct {
        logic [511:0] data;
        logic         sop;
        logic         eop;
        logic [5:0]   empty;
    } rec_t;

    rec_t beat_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_beats = 0;

    always #5 clk = ~clk;

    adc_st_packetizer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .smp_data  (smp_data),
        .smp_valid (smp_valid),
        .trig      (trig),
        .pkt_len   (pkt_len),
        .st_data   (st_data),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_sop    (st_sop),
        .st_eop    (st_eop),
        .st_empty  (st_empty),
        .busy      (busy),
        .ovf_cnt   (ovf_cnt),
        .pkt_seq   (pkt_seq)
    );

    // Ready is stable between edges, so valid&ready at negedge means a transfer at the next posedge.
    always @(negedge clk) begin
        if (reset_n && st_valid && st_ready) begin
            rec_t r;
            r.data  = st_data;
            r.sop   = st_sop;
            r.eop   = st_eop;
            r.empty = st_empty;
            beat_q.push_back(r);
            $display("beat %0d sop=%0b eop=%0b empty=%0d top=%08h", n_beats, st_sop, st_eop,
                     st_empty, st_data[511:480]);
            n_beats++;
        end
    end

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] exp_data(input int first, input int n);
        logic [511:0] d;
        d = '0;
        for (int i = 0; i < n; i++) begin
            d[511 - i*32 -: 32] = 32'(first + i);
        end
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_trig(input int len);
        trig    = 1'b1;
        pkt_len = 16'(len);
        tick();
        trig    = 1'b0;
    endtask

    task automatic send_samples(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            smp_valid = 1'b1;
            smp_data  = 32'(first + i);
            tick();
        end
        smp_valid = 1'b0;
    endtask

    task automatic wait_beats(input string tag, input int n);
        for (int i = 0; i < 60 && beat_q.size() < n; i++) begin
            tick();
        end
        check({tag, "_count"}, beat_q.size(), n);
    endtask

    task automatic check_beat(input string tag, input logic [511:0] data, input logic sop,
                              input logic eop, input logic [5:0] empty);
        rec_t r;
        if (beat_q.size() == 0) begin
            check({tag, "_present"}, 0, 1);
        end else begin
            r = beat_q.pop_front();
            check({tag, "_data"}, r.data, data);
            check({tag, "_sop"}, r.sop, sop);
            check({tag, "_eop"}, r.eop, eop);
            check({tag, "_empty"}, r.empty, empty);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        check("rst_valid", st_valid, 0);
        check("rst_data", st_data, 0);
        check("rst_sop", st_sop, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", ovf_cnt, 0);
        check("rst_seq", pkt_seq, 0);
        reset_n = 1'b1;
        tick();
        beat_q.delete();
    endtask

    initial begin
        do_reset();

`ifdef ADC_PKT_HEADER_EN
        send_trig(16);
        tick();
        send_samples(1, 16);
        wait_beats("t6", 2);
        if (beat_q.size() >= 2) begin
            rec_t h;
            h = beat_q.pop_front();
            check("t6_magic", h.data[511:480], 32'hADC0_5EED);
            check("t6_seq", h.data[479:448], 1);
            check("t6_len", h.data[367:352], 16);
            check("t6_hsop", h.sop, 1);
            check("t6_heop", h.eop, 0);
            check_beat("t6_d", exp_data(1, 16), 1'b0, 1'b1, 6'd0);
        end
`else
        // 1: single full beat, plus output latency
        send_trig(16);
        send_samples(1, 16);
        check("t1_lat_early", st_valid, 0);
        tick();
        check("t1_lat_valid", st_valid, 1);
        wait_beats("t1", 1);
        check_beat("t1_b0", exp_data(1, 16), 1'b1, 1'b1, 6'd0);
        check("t1_busy", busy, 0);

        // 2: partial last beat
        send_trig(20);
        send_samples(1, 20);
        wait_beats("t2", 2);
        check_beat("t2_b0", exp_data(1, 16), 1'b1, 1'b0, 6'd0);
        check_beat("t2_b1", exp_data(17, 4), 1'b0, 1'b1, 6'd48);

        // 3: backpressure overflow into ABORT
        st_ready = 1'b0;
        send_trig(256);
        send_samples(1, 256);
        check("t3_ovf", ovf_cnt, 176);
        check("t3_busy", busy, 1);
        check("t3_hold_valid", st_valid, 1);
        check("t3_hold_data", st_data, exp_data(1, 16));
        check("t3_hold_sop", st_sop, 1);
        st_ready = 1'b1;
        wait_beats("t3", 5);
        for (int k = 0; k < 5; k++) begin
            check_beat($sformatf("t3_b%0d", k), exp_data(1 + 16*k, 16), k == 0, k == 4, 6'd0);
        end
        check("t3_idle", busy, 0);
        check("t3_seq", pkt_seq, 3);

        // 4: ignored triggers
        send_trig(0);
        check("t4_len0_busy", busy, 0);
        check("t4_len0_seq", pkt_seq, 3);
        send_trig(8);
        send_samples(1, 3);
        send_trig(16);
        check("t4_mid_seq", pkt_seq, 4);
        check("t4_mid_busy", busy, 1);
        send_samples(4, 5);
        wait_beats("t4", 1);
        check_beat("t4_b0", exp_data(1, 8), 1'b1, 1'b1, 6'd32);
        check("t4_idle", busy, 0);

        // 5: asynchronous reset mid-packet
        send_trig(16);
        send_samples(1, 7);
        check("t5_busy_pre", busy, 1);
        #3 reset_n = 1'b0;
        #1;
        check("t5_busy", busy, 0);
        check("t5_valid", st_valid, 0);
        check("t5_seq", pkt_seq, 0);
        check("t5_ovf", ovf_cnt, 0);
        tick();
        reset_n = 1'b1;
        tick();
        beat_q.delete();
        send_trig(16);
        send_samples(101, 16);
        wait_beats("t5", 1);
        check_beat("t5_b0", exp_data(101, 16), 1'b1, 1'b1, 6'd0);
        check("t5_seq_new", pkt_seq, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
